fp16_op_dispatcher: RTL and testbench

Hardware initiator for the FP16 add/sub unit. It accepts queued operation requests from a host over a valid/ready interface and issues them one at a time to the unit's start/done handshake. It captures each result and returns it in order over a valid/ready response interface. It sits between the control/datapath sequencer and the add/sub core.

---
 rtl/fp16_pkg.sv | 7 +
 rtl/fp16_req_fifo.sv | 34 +++
 rtl/fp16_op_dispatcher.sv | 101 ++++++++++
 tb/tb_fp16_op_dispatcher.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 constants, opcode and dispatcher state encodings
package fp16_pkg;
    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/fp16_req_fifo.sv
// fp16_req_fifo: synchronous request queue with full/empty flags
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fp16_req_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fp16_op_dispatcher.sv
// fp16_op_dispatcher: queues add/sub requests and issues them one at a time to the FP16 core
// Optional abort of a hung core after TIMEOUT_CYCLES wait cycles: define DISPATCH_TIMEOUT_EN.
module fp16_op_dispatcher
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH     = FP16_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_timeout,
    output logic [DATA_WIDTH-1:0] fpu_in_a,
    output logic [DATA_WIDTH-1:0] fpu_in_b,
    output logic                  fpu_opcode,
    output logic                  fpu_start,
    input  logic [DATA_WIDTH-1:0] fpu_out,
    input  logic                  fpu_done,
    output logic                  busy
);
    localparam int EW = 2 * DATA_WIDTH + 1;
    state_t state;
    logic [EW-1:0] head;
    logic full, empty;
    assign req_ready = !full;
    assign busy      = (state != S_IDLE) || !empty;
    fp16_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(req_valid && req_ready),
        .pop(state == S_IDLE && !empty),
        .din({req_a, req_b, req_op}),
        .dout(head),
        .full(full),
        .empty(empty)
    );
`ifdef DISPATCH_TIMEOUT_EN
    localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] wait_cnt;
`else
    assign rsp_timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fpu_start  <= 1'b0;
            fpu_in_a   <= '0;
            fpu_in_b   <= '0;
            fpu_opcode <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (!empty) begin
                    {fpu_in_a, fpu_in_b, fpu_opcode} <= head;
                    fpu_start <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    fpu_start <= 1'b0;
                    state     <= S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: if (fpu_done) begin
                    rsp_data  <= fpu_out;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
`ifdef DISPATCH_TIMEOUT_EN
                    rsp_timeout <= 1'b0;
                end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data    <= DATA_WIDTH'(FP16_QNAN);
                    rsp_timeout <= 1'b1;
                    rsp_valid   <= 1'b1;
                    state       <= S_RESP;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_op_dispatcher.sv
// tb_fp16_op_dispatcher: directed table-driven bench with a table-lookup FP16 core model
// Exercises the timeout path when DISPATCH_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_fp16_op_dispatcher;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_op = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_a = '0, req_b = '0;
    logic req_ready, rsp_valid, rsp_timeout, fpu_opcode, fpu_start, busy, fpu_done;
    logic [15:0] rsp_data, fpu_in_a, fpu_in_b, fpu_out;
    logic core_done = 1'b0, spur_done = 1'b0, hang = 1'b0;
    logic [15:0] core_out = '0, spur_out = '0;
    int delay = 3, start_cnt = 0, passed = 0, total = 0;
    vec_t vec [12];

    assign fpu_done = core_done | spur_done;
    assign fpu_out  = spur_done ? spur_out : core_out;

    fp16_op_dispatcher #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .fpu_in_a(fpu_in_a), .fpu_in_b(fpu_in_b),
        .fpu_opcode(fpu_opcode), .fpu_start(fpu_start), .fpu_out(fpu_out),
        .fpu_done(fpu_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (fpu_start) start_cnt <= start_cnt + 1;

    function automatic logic [15:0] lookup(logic [15:0] a, logic [15:0] b, logic op);
        for (int i = 0; i < 12; i++)
            if (vec[i].a == a && vec[i].b == b && vec[i].op == op) return vec[i].res;
        return 16'hDEAD;
    endfunction

    // Core stand-in: answers `delay` cycles after each start unless hung.
    initial begin
        int cnt;
        logic pending;
        logic [15:0] la, lb;
        logic lop;
        cnt = 0; pending = 1'b0; la = '0; lb = '0; lop = 1'b0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (rst) pending = 1'b0;
            else if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_out  = lookup(la, lb, lop);
                    pending   = 1'b0;
                end
            end else if (fpu_start && !hang) begin
                pending = 1'b1; cnt = delay; la = fpu_in_a; lb = fpu_in_b; lop = fpu_opcode;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(vec_t v);
        int g;
        g = 0;
        req_valid = 1'b1; req_a = v.a; req_b = v.b; req_op = v.op;
        while (!req_ready && g < 200) begin tick(); g++; end
        if (g >= 200) chk("push_timeout", 0, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(string name, logic [15:0] data, logic to);
        int g;
        g = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && g < 300) begin tick(); g++; end
        chk({name, "_valid"}, rsp_valid, 1);
        chk({name, "_data"}, rsp_data, data);
        chk({name, "_timeout"}, rsp_timeout, to);
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int s0, acc;
        logic stable;
        logic [15:0] held;
        vec = '{
            '{16'h3C00, 16'h3C00, 1'b0, 16'h4000}, '{16'h4000, 16'h3C00, 1'b1, 16'h3C00},
            '{16'h3C00, 16'h4000, 1'b0, 16'h4200}, '{16'h4200, 16'h4000, 1'b1, 16'h3C00},
            '{16'h4400, 16'h4400, 1'b0, 16'h4800}, '{16'h3800, 16'h3800, 1'b0, 16'h3C00},
            '{16'h4800, 16'h4400, 1'b1, 16'h4400}, '{16'h3C00, 16'h3C00, 1'b1, 16'h0000},
            '{16'h4500, 16'h3C00, 1'b0, 16'h4600}, '{16'hC000, 16'h3C00, 1'b0, 16'hBC00},
            '{16'h4900, 16'h4000, 1'b1, 16'h4800}, '{16'h3400, 16'h3400, 1'b0, 16'h3800}
        };
        tick(); tick();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {rsp_data, rsp_timeout, fpu_opcode}, 0);
        chk("rst_fpu_in", {fpu_in_a, fpu_in_b}, 0);

        // single op with latency and start-pulse width
        s0 = start_cnt;
        push(vec[0]);
        chk("lat_n1_start", fpu_start, 0);
        chk("lat_n1_busy", busy, 1);
        tick();
        chk("lat_n2_start", fpu_start, 1);
        chk("lat_n2_in", {fpu_in_a, fpu_in_b, 15'd0, fpu_opcode}, {16'h3C00, 16'h3C00, 16'h0000});
        tick();
        chk("lat_n3_start", fpu_start, 0);
        get_rsp("single", 16'h4000, 0);
        chk("single_busy_after", busy, 0);
        chk("single_start_cnt", start_cnt - s0, 1);

        for (int i = 1; i < 6; i++) begin
            delay = 1 + i % 3;
            push(vec[i]);
            get_rsp($sformatf("vec%0d", i), vec[i].res, 0);
        end
        delay = 2;

        // fill under response backpressure
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_a = vec[2 + i].a; req_b = vec[2 + i].b; req_op = vec[2 + i].op;
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_ready_low", req_ready, 0);
        repeat (4) tick();
        chk("fill_ready_still_low", req_ready, 0);
        chk("fill_rsp_pending", rsp_valid, 1);
        for (int i = 0; i < 5; i++) get_rsp($sformatf("fill%0d", i), vec[2 + i].res, 0);
        repeat (3) tick();
        chk("fill_no_extra", rsp_valid, 0);
        chk("fill_idle", busy, 0);

        // response stall with a second op queued
        push(vec[8]);
        push(vec[9]);
        while (!rsp_valid) tick();
        held = rsp_data; s0 = start_cnt; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_data !== held) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_held_data", held, 16'h4600);
        chk("stall_no_start", start_cnt - s0, 0);
        get_rsp("stall_a", 16'h4600, 0);
        get_rsp("stall_b", 16'hBC00, 0);

        // done pulses outside WAIT are ignored
        hang = 1'b1;
        spur_out = 16'h1111; spur_done = 1'b1; tick(); spur_done = 1'b0;
        chk("spur_idle", {rsp_valid, busy}, 0);
        push(vec[10]);
        tick();
        chk("spur_issue_cycle", fpu_start, 1);
        spur_done = 1'b1; tick(); spur_done = 1'b0;
        tick(); tick();
        chk("spur_issue_ignored", rsp_valid, 0);
        chk("spur_in_stable", fpu_in_a, 16'h4900);
        spur_out = 16'h2222; spur_done = 1'b1; tick(); spur_done = 1'b0;
        hang = 1'b0;
        get_rsp("spur_wait", 16'h2222, 0);

`ifdef DISPATCH_TIMEOUT_EN
        hang = 1'b1;
        push(vec[10]);
        push(vec[11]);
        while (!fpu_start) tick();
        tick();
        repeat (7) tick();
        chk("to_not_yet", rsp_valid, 0);
        tick();
        chk("to_fired", rsp_valid, 1);
        hang = 1'b0;
        get_rsp("to_abort", 16'h7E00, 1);
        get_rsp("to_next", 16'h3800, 0);
        delay = 8;
        push(vec[0]);
        get_rsp("to_done_same_cycle", 16'h4000, 0);
        delay = 9;
        push(vec[1]);
        get_rsp("to_done_late", 16'h7E00, 1);
        repeat (3) tick();
        chk("to_late_done_ignored", {rsp_valid, busy}, 0);
        delay = 2;
`else
        hang = 1'b1;
        push(vec[10]);
        repeat (500) tick();
        chk("hang_still_waiting", {rsp_valid, busy}, 2'b01);
        chk("hang_no_timeout", rsp_timeout, 0);
        rst = 1'b1; tick(); rst = 1'b0;
`endif

        // reset in WAIT with two entries queued
        hang = 1'b1;
        push(vec[3]); push(vec[4]); push(vec[5]);
        chk("mid_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_start", fpu_start, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        hang = 1'b0;
        push(vec[6]);
        get_rsp("after_rst", 16'h4400, 0);
        repeat (3) tick();
        chk("after_rst_idle", {rsp_valid, busy}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end
endmodule
